// File: rtl/sattn_pkg.sv
// Shared types and constants for the sparse-attention top-K selection path.
package sattn_pkg;

  localparam int K_MAX   = 16;
  localparam int SCORE_W = 32;
  localparam int IDX_W   = 16;
  localparam int RANK_W  = $clog2(K_MAX);

  // Command code the decoder uses to launch a top-K index selection.
  localparam logic [7:0] CMD_TOPK_IDX = 8'h2A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef struct packed {
    logic                      valid;
    logic signed [SCORE_W-1:0] score;
    logic [IDX_W-1:0]          index;
  } slot_t;

  function automatic logic [IDX_W-1:0] min3(input logic [IDX_W-1:0] a,
                                            input logic [IDX_W-1:0] b,
                                            input logic [IDX_W-1:0] c);
    logic [IDX_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/topk_block_select_if.sv
// Score stream and index-RAM write port of topk_block_select.
interface topk_block_select_if;
  import sattn_pkg::*;

  // Score beat transfers on a cycle where score_valid && score_ready; score_data
  // must be stable while score_valid is high. idx_wen is a fire-and-forget strobe.
  logic                      score_valid;
  logic                      score_ready;
  logic signed [SCORE_W-1:0] score_data;
  logic                      idx_wen;
  logic [IDX_W-1:0]          idx_waddr;
  logic [IDX_W-1:0]          idx_wdata;

  modport master (
    output score_valid, score_data,
    input  score_ready, idx_wen, idx_waddr, idx_wdata
  );

  modport slave (
    input  score_valid, score_data,
    output score_ready, idx_wen, idx_waddr, idx_wdata
  );

endinterface

// File: rtl/topk_sorter.sv
// K_MAX-slot sorted insertion array, rank 0 = highest score.
// TOPK_SINK_EN: block 0 is pinned at rank 0 as the attention-sink block.
module topk_sorter
  import sattn_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_i,
  input  logic                      insert_i,
  input  logic signed [SCORE_W-1:0] ins_score_i,
  input  logic [IDX_W-1:0]          ins_index_i,
  input  logic [RANK_W-1:0]         rd_rank_i,
  output logic [IDX_W-1:0]          rd_index_o
);

  slot_t            slot_q [K_MAX];
  slot_t            slot_d [K_MAX];
  slot_t            new_slot;
  logic [K_MAX-1:0] ahead;

  assign new_slot = '{valid: 1'b1, score: ins_score_i, index: ins_index_i};

  // Strict compare keeps the earlier block ahead on equal scores; the array is
  // always sorted, so ahead[] is a thermometer code (0..0 1..1).
  always_comb begin
    for (int j = 0; j < K_MAX; j++) begin
      ahead[j] = !slot_q[j].valid || ($signed(ins_score_i) > $signed(slot_q[j].score));
`ifdef TOPK_SINK_EN
      if (slot_q[j].valid && (slot_q[j].index == '0)) ahead[j] = 1'b0;
`endif
    end
  end

  always_comb begin
    for (int j = 0; j < K_MAX; j++) slot_d[j] = slot_q[j];
    if (insert_i) begin
      if (ahead[0]) slot_d[0] = new_slot;
      for (int j = 1; j < K_MAX; j++) begin
        if (ahead[j]) slot_d[j] = ahead[j-1] ? slot_q[j-1] : new_slot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      for (int j = 0; j < K_MAX; j++) slot_q[j] <= '0;
    end else begin
      for (int j = 0; j < K_MAX; j++) slot_q[j] <= slot_d[j];
    end
  end

  assign rd_index_o = slot_q[rd_rank_i].index;

endmodule

// File: rtl/topk_block_select.sv
// Top-K block selector: collects block scores, keeps the top K sorted, writes indices to the index RAM.
// TOPK_SINK_EN (see topk_sorter) keeps block 0 at rank 0.
module topk_block_select
  import sattn_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [IDX_W-1:0]          k_blocks,
  input  logic [IDX_W-1:0]          n_blocks,
  input  logic [IDX_W-1:0]          idx_base_addr,
  topk_block_select_if.slave        bus,
  output logic [IDX_W-1:0]          sel_count,
  output logic                      busy,
  output logic                      done,
  output state_e                    state_dbg
);

  state_e           state_q;
  logic [IDX_W-1:0] k_eff_q;
  logic [IDX_W-1:0] n_q;
  logic [IDX_W-1:0] base_q;
  logic [IDX_W-1:0] beat_q;
  logic [IDX_W-1:0] wr_q;
  logic [IDX_W-1:0] sel_count_q;
  logic             done_q;
  logic             idx_wen_q;
  logic [IDX_W-1:0] idx_waddr_q;
  logic [IDX_W-1:0] idx_wdata_q;

  logic [IDX_W-1:0] k_eff_d;
  logic             accept;
  logic             sorter_clear;
  logic [IDX_W-1:0] rd_index;

  assign k_eff_d      = min3(k_blocks, IDX_W'(K_MAX), n_blocks);
  assign accept       = bus.score_valid && (state_q == ST_COLLECT);
  assign sorter_clear = (state_q == ST_IDLE) && start;

  topk_sorter u_sorter (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (sorter_clear),
    .insert_i    (accept),
    .ins_score_i (bus.score_data),
    .ins_index_i (beat_q),
    .rd_rank_i   (wr_q[RANK_W-1:0]),
    .rd_index_o  (rd_index)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_eff_q     <= '0;
      n_q         <= '0;
      base_q      <= '0;
      beat_q      <= '0;
      wr_q        <= '0;
      sel_count_q <= '0;
      done_q      <= 1'b0;
      idx_wen_q   <= 1'b0;
      idx_waddr_q <= '0;
      idx_wdata_q <= '0;
    end else begin
      done_q    <= 1'b0;
      idx_wen_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            k_eff_q <= k_eff_d;
            n_q     <= n_blocks;
            base_q  <= idx_base_addr;
            beat_q  <= '0;
            wr_q    <= '0;
            state_q <= (k_eff_d == '0) ? ST_DONE : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == n_q - 1'b1) state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Address arithmetic wraps modulo 2^IDX_W by width truncation.
          idx_wen_q   <= 1'b1;
          idx_waddr_q <= base_q + wr_q;
          idx_wdata_q <= rd_index;
          wr_q        <= wr_q + 1'b1;
          if (wr_q == k_eff_q - 1'b1) state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q      <= 1'b1;
          sel_count_q <= k_eff_q;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.score_ready = (state_q == ST_COLLECT);
  assign bus.idx_wen     = idx_wen_q;
  assign bus.idx_waddr   = idx_waddr_q;
  assign bus.idx_wdata   = idx_wdata_q;
  assign sel_count       = sel_count_q;
  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_topk_block_select.sv
// Directed bench for topk_block_select; expectations follow TOPK_SINK_EN when defined.
module tb_topk_block_select;
  import sattn_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [IDX_W-1:0] k_blocks = '0;
  logic [IDX_W-1:0] n_blocks = '0;
  logic [IDX_W-1:0] idx_base_addr = '0;
  logic [IDX_W-1:0] sel_count;
  logic             busy;
  logic             done;
  state_e           state_dbg;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int last_wen_cyc = 0;
  int done_cnt = 0;
  int wr_seen = 0;
  int exp_n = 0;
  int scores [64];
  int t1_s [8] = '{5, 9, 1, 9, 3, 7, 0, 2};
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  topk_block_select_if bus ();

  topk_block_select dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .k_blocks      (k_blocks),
    .n_blocks      (n_blocks),
    .idx_base_addr (idx_base_addr),
    .bus           (bus),
    .sel_count     (sel_count),
    .busy          (busy),
    .done          (done),
    .state_dbg     (state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus.idx_wen) begin
        last_wen_cyc = cyc;
        wr_seen++;
        check("wr_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("wr", {bus.idx_waddr, bus.idx_wdata}, exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        if (exp_n > 0) check("done_lat", cyc - last_wen_cyc, 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input int base, input int i, input int data);
    logic [15:0] a;
    a = 16'(base + i);
    exp_q.push_back({a, 16'(data)});
  endtask

  task automatic load_t1();
    for (int i = 0; i < 8; i++) scores[i] = t1_s[i];
  endtask

  task automatic push_t1(input int base);
`ifdef TOPK_SINK_EN
    push_exp(base, 0, 0); push_exp(base, 1, 1); push_exp(base, 2, 3);
`else
    push_exp(base, 0, 1); push_exp(base, 1, 3); push_exp(base, 2, 5);
`endif
  endtask

  task automatic run_sel(input int k, input int n, input int base, input int duty,
                         input int exp_sel, input string tag);
    int beat;
    int guard;
    int d0;
    logic v;
    d0 = done_cnt;
    exp_n = exp_sel;
    @(negedge clk);
    k_blocks = 16'(k); n_blocks = 16'(n); idx_base_addr = 16'(base); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (exp_sel == 0) begin
      bus.score_valid = 1'b1;
      bus.score_data  = 32'sd5;
      check({tag, "_busy"}, busy, 1);
      check({tag, "_ready_low"}, bus.score_ready, 0);
      check({tag, "_no_early_done"}, done, 0);
      @(negedge clk);
    end else begin
      beat = 0;
      guard = 0;
      while (beat < n && guard < 1000) begin
        v = ($urandom_range(0, 99) < duty);
        bus.score_valid = v;
        bus.score_data  = scores[beat];
        #1;
        if (v && bus.score_ready) beat++;
        @(negedge clk);
        guard++;
      end
      check({tag, "_beats"}, beat, n);
      // Extra beat that would outrank everything if it were wrongly accepted.
      bus.score_valid = 1'b1;
      bus.score_data  = 32'sh7FFF_FFFF;
      check({tag, "_ready_drop"}, bus.score_ready, 0);
    end
    guard = 0;
    while (!done && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_sel_count"}, sel_count, exp_sel);
    bus.score_valid = 1'b0;
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_sel_hold"}, sel_count, exp_sel);
    check({tag, "_done_cnt"}, done_cnt - d0, 1);
    check({tag, "_wr_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wr0;
    int dc0;
    bus.score_valid = 1'b0;
    bus.score_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wen", bus.idx_wen, 0);
    check("rst_ready", bus.score_ready, 0);
    check("rst_sel", sel_count, 0);
    check("rst_state", state_dbg, ST_IDLE);
    rst = 1'b0;
    @(negedge clk);

    // Basic selection with a tie on score 9.
    load_t1();
    push_t1(16'h0010);
    run_sel(3, 8, 16'h0010, 100, 3, "t1");

    // k=0: straight to DONE.
    run_sel(0, 8, 16'h0020, 100, 0, "t2");

    // k capped at K_MAX, ascending scores.
    for (int i = 0; i < 32; i++) scores[i] = i;
`ifdef TOPK_SINK_EN
    push_exp(16'h0100, 0, 0);
    for (int i = 1; i < 16; i++) push_exp(16'h0100, i, 32 - i);
`else
    for (int i = 0; i < 16; i++) push_exp(16'h0100, i, 31 - i);
`endif
    run_sel(20, 32, 16'h0100, 100, 16, "t3");

    // Same as t1 with a gappy valid.
    load_t1();
    push_t1(16'h0010);
    run_sel(3, 8, 16'h0010, 50, 3, "t4");

    // Address wrap.
    for (int i = 0; i < 4; i++) scores[i] = i + 1;
`ifdef TOPK_SINK_EN
    push_exp(16'hFFFE, 0, 0); push_exp(16'hFFFE, 1, 3); push_exp(16'hFFFE, 2, 2);
`else
    push_exp(16'hFFFE, 0, 3); push_exp(16'hFFFE, 1, 2); push_exp(16'hFFFE, 2, 1);
`endif
    run_sel(3, 4, 16'hFFFE, 100, 3, "t5");

    // Signed compare: -1 must rank below 5; n limits k_eff.
    scores[0] = -1; scores[1] = 5; scores[2] = -8;
`ifdef TOPK_SINK_EN
    push_exp(16'h0040, 0, 0); push_exp(16'h0040, 1, 1);
`else
    push_exp(16'h0040, 0, 1); push_exp(16'h0040, 1, 0);
`endif
    run_sel(2, 3, 16'h0040, 100, 2, "sgn");

    // n=0: no writes.
    run_sel(5, 0, 16'h0050, 100, 0, "n0");

    // Reset in the middle of COLLECT.
    wr0 = wr_seen;
    dc0 = done_cnt;
    load_t1();
    @(negedge clk);
    k_blocks = 16'd3; n_blocks = 16'd8; idx_base_addr = 16'h0010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.score_valid = 1'b1;
      bus.score_data  = scores[i];
      @(negedge clk);
    end
    check("t6_mid_busy", busy, 1);
    rst = 1'b1;
    bus.score_valid = 1'b0;
    @(negedge clk);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_wen", bus.idx_wen, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_state", state_dbg, ST_IDLE);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_no_wr", wr_seen - wr0, 0);
    check("t6_no_done", done_cnt - dc0, 0);
    push_t1(16'h0010);
    run_sel(3, 8, 16'h0010, 100, 3, "t6_rerun");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
